// File: rtl/bus_arb_pkg.sv
// ---------------------------------------------------------------------------
// bus_arb_pkg
// Shared types and constants for the two-master bus arbiter.
//   bus_arb_state_t      : arbiter FSM states (IDLE, ISSUE, RESP)
//   bus_arb_req_t        : one latched request (addr, wdata, wmask, is_write)
//   BUS_ARB_TIMEOUT_DATA : read data returned when the slave watchdog fires
//   make_req()           : builds a request record from raw master inputs
// ---------------------------------------------------------------------------
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } bus_arb_state_t;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic        is_write;
    } bus_arb_req_t;

    localparam logic [31:0] BUS_ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

    // A master asserting both wen and ren is treated as a write, so the
    // operation is fully described by wen alone.
    function automatic bus_arb_req_t make_req(
        input logic [31:0] addr,
        input logic [31:0] wdata,
        input logic [3:0]  wmask,
        input logic        wen
    );
        bus_arb_req_t r;
        r.addr     = addr;
        r.wdata    = wdata;
        r.wmask    = wmask;
        r.is_write = wen;
        return r;
    endfunction

endpackage

// File: rtl/bus_arb_rr_pick.sv
// ---------------------------------------------------------------------------
// bus_arb_rr_pick
// Combinational two-input winner picker.
//   FIXED_PRIORITY : 0 = round-robin tie break, 1 = master 0 wins ties
//   req            : in  2  request vector, bit i = master i requesting
//   last_served    : in  1  index of the master served most recently
//   win            : out 2  one-hot winner, 00 when nobody requests
// ---------------------------------------------------------------------------
module bus_arb_rr_pick #(
    parameter int FIXED_PRIORITY = 0
) (
    input  logic [1:0] req,
    input  logic       last_served,
    output logic [1:0] win
);

    // A lone requester always wins; on a tie either master 0 is favoured
    // outright or the master that was not served last gets its turn.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11: begin
                if (FIXED_PRIORITY != 0 || last_served) begin
                    win = 2'b01;
                end else begin
                    win = 2'b10;
                end
            end
            default: win = 2'b00;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master, one-slave arbiter for the 32-bit CPU data bus. Master 0 is the
// CPU load/store port, master 1 the debug/DMA loader. One request at a time
// is latched, held on the slave until s_done, then answered with a one-cycle
// done pulse to the granted master.
//
// Optional feature macro: BUS_ARB_TIMEOUT_EN enables a slave watchdog that
// forces a response (rdata = 32'hDEAD_BEEF) and sets a sticky timeout_err
// after TIMEOUT_CYCLES cycles in ISSUE without s_done.
//
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   m0_*/m1_* addr,wdata,    master request inputs (wen wins over ren)
//   wmask,wen,ren
//   m0_rdata/m1_rdata        read response data (shared latched value)
//   m0_done/m1_done          one-cycle completion pulse
//   s_addr,s_wdata,s_wmask,  slave request, driven only in ISSUE
//   s_wen,s_ren
//   s_rdata,s_done           slave response
//   grant                    one-hot active master, 00 when idle
//   timeout_err              sticky watchdog flag (0 without the feature)
// ---------------------------------------------------------------------------
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int FIXED_PRIORITY = 0,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m0_wmask,
    input  logic [3:0]  m1_wmask,
    input  logic        m0_wen,
    input  logic        m1_wen,
    input  logic        m0_ren,
    input  logic        m1_ren,
    output logic [31:0] m0_rdata,
    output logic [31:0] m1_rdata,
    output logic        m0_done,
    output logic        m1_done,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wmask,
    output logic        s_wen,
    output logic        s_ren,
    input  logic [31:0] s_rdata,
    input  logic        s_done,
    output logic [1:0]  grant,
    output logic        timeout_err
);

    if (TIMEOUT_CYCLES < 2) begin : g_timeout_check
        $error("bus_arbiter: TIMEOUT_CYCLES must be at least 2");
    end

    bus_arb_state_t state;
    bus_arb_state_t next_state;
    bus_arb_req_t   cur_req;
    bus_arb_req_t   new_req;
    logic [1:0]     req_vec;
    logic [1:0]     win;
    logic [1:0]     grant_q;
    logic           last_q;
    logic [31:0]    rdata_q;
    logic           timeout_hit;

    assign req_vec = {m1_wen | m1_ren, m0_wen | m0_ren};

    bus_arb_rr_pick #(
        .FIXED_PRIORITY(FIXED_PRIORITY)
    ) u_pick (
        .req        (req_vec),
        .last_served(last_q),
        .win        (win)
    );

    assign new_req = win[1] ? make_req(m1_addr, m1_wdata, m1_wmask, m1_wen)
                            : make_req(m0_addr, m0_wdata, m0_wmask, m0_wen);

`ifdef BUS_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             timeout_flag;

    // wait_cnt holds the number of ISSUE cycles already completed, so the
    // watchdog fires during the TIMEOUT_CYCLES-th ISSUE cycle. A real s_done
    // in that same cycle still wins.
    assign timeout_hit = (state == ISSUE) && !s_done &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Counter parks at zero outside ISSUE so it is clear on every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt     <= '0;
            timeout_flag <= 1'b0;
        end else begin
            if (state == ISSUE) begin
                wait_cnt <= wait_cnt + 1'b1;
            end else begin
                wait_cnt <= '0;
            end
            if (timeout_hit) begin
                timeout_flag <= 1'b1;
            end
        end
    end

    assign timeout_err = timeout_flag;
`else
    assign timeout_hit = 1'b0;
    assign timeout_err = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. RESP always returns to IDLE, which guarantees at
    // least one idle cycle between transactions.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (|req_vec) next_state = ISSUE;
            ISSUE:   if (s_done || timeout_hit) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Request latch, response latch, grant and last-served pointer.
    // Reset leaves master 1 as last served so master 0 wins the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur_req <= '0;
            grant_q <= 2'b00;
            last_q  <= 1'b1;
            rdata_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_vec) begin
                        cur_req <= new_req;
                        grant_q <= win;
                    end
                end
                ISSUE: begin
                    if (s_done) begin
                        rdata_q <= s_rdata;
                    end else if (timeout_hit) begin
                        rdata_q <= BUS_ARB_TIMEOUT_DATA;
                    end
                end
                RESP: begin
                    last_q  <= grant_q[1];
                    grant_q <= 2'b00;
                end
                default: grant_q <= 2'b00;
            endcase
        end
    end

    // Outputs: slave side is live only in ISSUE, done pulses only in RESP.
    always_comb begin
        s_addr  = '0;
        s_wdata = '0;
        s_wmask = '0;
        s_wen   = 1'b0;
        s_ren   = 1'b0;
        m0_done = 1'b0;
        m1_done = 1'b0;
        if (state == ISSUE) begin
            s_addr  = cur_req.addr;
            s_wdata = cur_req.wdata;
            s_wmask = cur_req.wmask;
            s_wen   = cur_req.is_write;
            s_ren   = !cur_req.is_write;
        end
        if (state == RESP) begin
            m0_done = grant_q[0];
            m1_done = grant_q[1];
        end
    end

    assign grant    = grant_q;
    assign m0_rdata = rdata_q;
    assign m1_rdata = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Self-checking bench for bus_arbiter. A round-robin instance (dut) and a
// fixed-priority instance (dut_fp) share every input; since the FSM timing
// does not depend on which master wins, both step through the same states.
// Build with BUS_ARB_TIMEOUT_EN defined to exercise the watchdog
// (TIMEOUT_CYCLES = 8 on both instances).
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

    logic        clk;
    logic        rst;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic [3:0]  m0_wmask, m1_wmask;
    logic        m0_wen, m1_wen, m0_ren, m1_ren;
    logic [31:0] s_rdata;
    logic        s_done;

    logic [31:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    logic        m0_done, m1_done, s_wen, s_ren, timeout_err;
    logic [3:0]  s_wmask;
    logic [1:0]  grant;

    logic [31:0] fp_m0_rdata, fp_m1_rdata, fp_s_addr, fp_s_wdata;
    logic        fp_m0_done, fp_m1_done, fp_s_wen, fp_s_ren, fp_timeout_err;
    logic [3:0]  fp_s_wmask;
    logic [1:0]  fp_grant;

    int checkCount = 0;
    int failCount  = 0;

    typedef struct {
        logic [31:0] m0a, m0d; logic [3:0] m0m; logic m0w, m0r;
        logic [31:0] m1a, m1d; logic [3:0] m1m; logic m1w, m1r;
        int          delay;
        logic [31:0] rdata;
        logic [1:0]  expGrant;
        logic [31:0] expAddr, expWdata;
        logic [3:0]  expWmask;
        logic        expWen;
    } vec_t;

    vec_t vecs[5];

    // Random-test reference: pending request per master and last-served index.
    logic [31:0] pa[2], pd[2];
    logic [3:0]  pm[2];
    logic        pw[2], pr[2], pv[2];
    int          modelLast;

    bus_arbiter #(.FIXED_PRIORITY(0), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wmask(m0_wmask), .m1_wmask(m1_wmask), .m0_wen(m0_wen), .m1_wen(m1_wen),
        .m0_ren(m0_ren), .m1_ren(m1_ren), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
        .m0_done(m0_done), .m1_done(m1_done), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_wmask(s_wmask), .s_wen(s_wen), .s_ren(s_ren), .s_rdata(s_rdata),
        .s_done(s_done), .grant(grant), .timeout_err(timeout_err)
    );

    bus_arbiter #(.FIXED_PRIORITY(1), .TIMEOUT_CYCLES(8)) dut_fp (
        .clk(clk), .rst(rst),
        .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_wmask(m0_wmask), .m1_wmask(m1_wmask), .m0_wen(m0_wen), .m1_wen(m1_wen),
        .m0_ren(m0_ren), .m1_ren(m1_ren), .m0_rdata(fp_m0_rdata), .m1_rdata(fp_m1_rdata),
        .m0_done(fp_m0_done), .m1_done(fp_m1_done), .s_addr(fp_s_addr), .s_wdata(fp_s_wdata),
        .s_wmask(fp_s_wmask), .s_wen(fp_s_wen), .s_ren(fp_s_ren), .s_rdata(s_rdata),
        .s_done(s_done), .grant(fp_grant), .timeout_err(fp_timeout_err)
    );

    // 10-unit clock period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case something upstream never returns.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired before the test sequence completed");
        $fatal(1, "[TB] watchdog");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checkCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s actual=%h expected=%h at t=%0t", name, actual, expected, $time);
        end
    endtask

    task automatic clearMasters();
        m0_addr = '0; m0_wdata = '0; m0_wmask = '0; m0_wen = 1'b0; m0_ren = 1'b0;
        m1_addr = '0; m1_wdata = '0; m1_wmask = '0; m1_wen = 1'b0; m1_ren = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        clearMasters();
        s_done = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    function automatic vec_t mkVec(
        input logic [31:0] m0a, m0d, input logic [3:0] m0m, input logic m0w, m0r,
        input logic [31:0] m1a, m1d, input logic [3:0] m1m, input logic m1w, m1r,
        input int delay, input logic [31:0] rdata, input logic [1:0] expGrant,
        input logic [31:0] expAddr, expWdata, input logic [3:0] expWmask, input logic expWen);
        vec_t v;
        v.m0a = m0a; v.m0d = m0d; v.m0m = m0m; v.m0w = m0w; v.m0r = m0r;
        v.m1a = m1a; v.m1d = m1d; v.m1m = m1m; v.m1w = m1w; v.m1r = m1r;
        v.delay = delay; v.rdata = rdata; v.expGrant = expGrant;
        v.expAddr = expAddr; v.expWdata = expWdata; v.expWmask = expWmask; v.expWen = expWen;
        return v;
    endfunction

    // Runs one full transaction from a table entry: request, hold for the
    // slave delay, answer, then confirm the done pulse and the idle cycle.
    task automatic applyStimulus(input vec_t v);
        m0_addr = v.m0a; m0_wdata = v.m0d; m0_wmask = v.m0m; m0_wen = v.m0w; m0_ren = v.m0r;
        m1_addr = v.m1a; m1_wdata = v.m1d; m1_wmask = v.m1m; m1_wen = v.m1w; m1_ren = v.m1r;
        s_done = 1'b0;
        step();
        checkOutput("vec_grant", 32'(grant), 32'(v.expGrant));
        checkOutput("vec_s_addr", s_addr, v.expAddr);
        checkOutput("vec_s_wdata", s_wdata, v.expWdata);
        checkOutput("vec_s_wmask", 32'(s_wmask), 32'(v.expWmask));
        checkOutput("vec_strobes", 32'({s_wen, s_ren}), 32'({v.expWen, !v.expWen}));
        checkOutput("vec_early_done", 32'({m1_done, m0_done}), 32'(0));
        for (int i = 0; i < v.delay; i++) begin
            step();
            checkOutput("vec_wmask_hold", 32'(s_wmask), 32'(v.expWmask));
            checkOutput("vec_strobe_hold", 32'({s_wen, s_ren}), 32'({v.expWen, !v.expWen}));
            checkOutput("vec_wait_done", 32'({m1_done, m0_done}), 32'(0));
        end
        s_rdata = v.rdata;
        s_done  = 1'b1;
        step();
        s_done = 1'b0;
        clearMasters();
        checkOutput("vec_done", 32'({m1_done, m0_done}), 32'(v.expGrant));
        checkOutput("vec_rdata", v.expGrant[0] ? m0_rdata : m1_rdata, v.rdata);
        checkOutput("vec_strobe_drop", 32'({s_wen, s_ren}), 32'(0));
        step();
        checkOutput("vec_idle_grant", 32'(grant), 32'(0));
        checkOutput("vec_idle_done", 32'({m1_done, m0_done}), 32'(0));
        checkOutput("vec_timeout_err", 32'(timeout_err), 32'(0));
    endtask

    task automatic newReq(input int m);
        pa[m] = $urandom;
        pd[m] = $urandom;
        pm[m] = 4'($urandom_range(0, 15));
        pw[m] = 1'($urandom_range(0, 1));
        pr[m] = pw[m] ? 1'($urandom_range(0, 1)) : 1'b1;
        pv[m] = 1'b1;
    endtask

    task automatic driveFromPending();
        m0_addr  = pv[0] ? pa[0] : '0;  m1_addr  = pv[1] ? pa[1] : '0;
        m0_wdata = pv[0] ? pd[0] : '0;  m1_wdata = pv[1] ? pd[1] : '0;
        m0_wmask = pv[0] ? pm[0] : '0;  m1_wmask = pv[1] ? pm[1] : '0;
        m0_wen   = pv[0] & pw[0];       m1_wen   = pv[1] & pw[1];
        m0_ren   = pv[0] & pr[0];       m1_ren   = pv[1] & pr[1];
    endtask

    // Randomised traffic against the reference: an unserved master keeps its
    // request pending, the served one retires it and may post a fresh one.
    task automatic randomTest(input int rounds);
        int w;
        int d;
        logic [31:0] rd;
        pv[0] = 1'b0;
        pv[1] = 1'b0;
        modelLast = 1;
        for (int r = 0; r < rounds; r++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pv[m] && $urandom_range(0, 1) == 1) newReq(m);
            end
            if (!pv[0] && !pv[1]) newReq(int'($urandom_range(0, 1)));
            driveFromPending();
            step();
            if (pv[0] && pv[1]) w = (modelLast == 1) ? 0 : 1;
            else                w = pv[0] ? 0 : 1;
            checkOutput("rnd_grant", 32'(grant), 32'(1 << w));
            checkOutput("rnd_s_addr", s_addr, pa[w]);
            checkOutput("rnd_s_wdata", s_wdata, pd[w]);
            checkOutput("rnd_s_wmask", 32'(s_wmask), 32'(pm[w]));
            checkOutput("rnd_strobes", 32'({s_wen, s_ren}), 32'({pw[w], !pw[w]}));
            d = int'($urandom_range(0, 3));
            for (int i = 0; i < d; i++) begin
                step();
                checkOutput("rnd_hold", 32'({s_wen, s_ren}), 32'({pw[w], !pw[w]}));
            end
            rd = $urandom;
            s_rdata = rd;
            s_done  = 1'b1;
            step();
            s_done = 1'b0;
            checkOutput("rnd_done", 32'({m1_done, m0_done}), 32'(1 << w));
            checkOutput("rnd_rdata", (w == 0) ? m0_rdata : m1_rdata, rd);
            pv[w] = 1'b0;
            modelLast = w;
            driveFromPending();
            step();
            checkOutput("rnd_idle_grant", 32'(grant), 32'(0));
            checkOutput("rnd_timeout_err", 32'(timeout_err), 32'(0));
        end
        clearMasters();
    endtask

    initial begin
        int n;
        rst = 1'b0;
        s_done = 1'b0;
        s_rdata = '0;
        clearMasters();

        // Directed table; expected grants assume master 1 served last at reset.
        vecs[0] = mkVec(32'h0000_1004, 32'h0, 4'h0, 1'b0, 1'b1,
                        32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                        0, 32'hCAFE_F00D, 2'b01, 32'h0000_1004, 32'h0, 4'h0, 1'b0);
        vecs[1] = mkVec(32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                        32'h2000_0000, 32'h0000_00AB, 4'b0001, 1'b1, 1'b0,
                        5, 32'h0000_5555, 2'b10, 32'h2000_0000, 32'h0000_00AB, 4'b0001, 1'b1);
        vecs[2] = mkVec(32'h0000_3000, 32'h1234_5678, 4'hF, 1'b1, 1'b1,
                        32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                        1, 32'h0BAD_F00D, 2'b01, 32'h0000_3000, 32'h1234_5678, 4'hF, 1'b1);
        vecs[3] = mkVec(32'h0000_0040, 32'h0, 4'h0, 1'b0, 1'b1,
                        32'h0000_0080, 32'h0, 4'h0, 1'b0, 1'b1,
                        2, 32'h1111_2222, 2'b10, 32'h0000_0080, 32'h0, 4'h0, 1'b0);
        vecs[4] = mkVec(32'h0000_0044, 32'hA5A5_A5A5, 4'b1100, 1'b1, 1'b0,
                        32'h0000_0088, 32'h0, 4'h0, 1'b0, 1'b1,
                        0, 32'h5566_7788, 2'b01, 32'h0000_0044, 32'hA5A5_A5A5, 4'b1100, 1'b1);

        // Reset state.
        step();
        step();
        checkOutput("rst_grant", 32'(grant), 32'(0));
        checkOutput("rst_strobes", 32'({s_wen, s_ren}), 32'(0));
        checkOutput("rst_s_addr", s_addr, 32'h0);
        checkOutput("rst_done", 32'({m1_done, m0_done}), 32'(0));
        checkOutput("rst_rdata", m0_rdata | m1_rdata, 32'h0);
        checkOutput("rst_timeout_err", 32'(timeout_err), 32'(0));
        rst = 1'b1;
        step();

        $display("[TB] directed table");
        for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

        $display("[TB] stray s_done while idle");
        s_done = 1'b1;
        step();
        s_done = 1'b0;
        checkOutput("stray_grant", 32'(grant), 32'(0));
        checkOutput("stray_strobes", 32'({s_wen, s_ren}), 32'(0));
        step();
        checkOutput("stray_done", 32'({m1_done, m0_done}), 32'(0));

        $display("[TB] continuous requests from both masters");
        doReset();
        m0_addr = 32'h0000_0100; m0_ren = 1'b1;
        m1_addr = 32'h0000_0200; m1_ren = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            checkOutput("rr_grant", 32'(grant), (k % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("rr_s_addr", s_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
            checkOutput("fp_grant", 32'(fp_grant), 32'd1);
            checkOutput("fp_s_addr", fp_s_addr, 32'h100);
            s_rdata = 32'(k + 16);
            s_done  = 1'b1;
            step();
            s_done = 1'b0;
            checkOutput("rr_done", 32'({m1_done, m0_done}), (k % 2 == 0) ? 32'd1 : 32'd2);
            checkOutput("fp_done", 32'({fp_m1_done, fp_m0_done}), 32'd1);
            step();
            checkOutput("rr_idle_grant", 32'(grant), 32'(0));
        end
        clearMasters();
        step();

        $display("[TB] reset during ISSUE");
        applyStimulus(mkVec(32'h0000_0500, 32'h0, 4'h0, 1'b0, 1'b1,
                            32'h0, 32'h0, 4'h0, 1'b0, 1'b0,
                            0, 32'h7777_8888, 2'b01, 32'h0000_0500, 32'h0, 4'h0, 1'b0));
        m1_addr = 32'h0000_0600; m1_ren = 1'b1;
        step();
        checkOutput("midrst_pre_ren", 32'(s_ren), 32'(1));
        checkOutput("midrst_pre_grant", 32'(grant), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("midrst_strobes", 32'({s_wen, s_ren}), 32'(0));
        checkOutput("midrst_s_addr", s_addr, 32'h0);
        checkOutput("midrst_grant", 32'(grant), 32'(0));
        checkOutput("midrst_rdata", m0_rdata | m1_rdata, 32'h0);
        checkOutput("midrst_done", 32'({m1_done, m0_done}), 32'(0));
        m0_addr = 32'h0000_0700; m0_ren = 1'b1;
        m1_addr = 32'h0000_0800; m1_ren = 1'b1;
        step();
        rst = 1'b1;
        step();
        checkOutput("postrst_grant", 32'(grant), 32'd1);
        checkOutput("postrst_s_addr", s_addr, 32'h0000_0700);
        s_rdata = 32'h0;
        s_done  = 1'b1;
        step();
        s_done = 1'b0;
        clearMasters();
        checkOutput("postrst_done", 32'({m1_done, m0_done}), 32'd1);
        step();

        $display("[TB] randomized traffic");
        doReset();
        randomTest(60);
        step();

`ifdef BUS_ARB_TIMEOUT_EN
        $display("[TB] slave never answers, watchdog");
        m0_addr = 32'h0000_0A00; m0_ren = 1'b1;
        n = 0;
        step();
        n++;
        while (!m0_done && n < 30) begin
            step();
            n++;
        end
        checkOutput("to_latency", 32'(n), 32'd9);
        checkOutput("to_rdata", m0_rdata, 32'hDEAD_BEEF);
        checkOutput("to_err", 32'(timeout_err), 32'(1));
        checkOutput("to_strobes", 32'({s_wen, s_ren}), 32'(0));
        clearMasters();
        repeat (3) step();
        checkOutput("to_err_sticky", 32'(timeout_err), 32'(1));
        checkOutput("to_idle_grant", 32'(grant), 32'(0));
`else
        $display("[TB] slow slave, no watchdog");
        m1_addr = 32'h0000_0900; m1_wdata = 32'h0000_0042; m1_wmask = 4'b0010; m1_wen = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (m1_done || !s_wen) n++;
        end
        checkOutput("slow_no_done", 32'(n), 32'(0));
        s_rdata = 32'h0;
        s_done  = 1'b1;
        step();
        s_done = 1'b0;
        clearMasters();
        checkOutput("slow_done", 32'({m1_done, m0_done}), 32'd2);
        checkOutput("slow_timeout_err", 32'(timeout_err), 32'(0));
        step();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
# bus_arbiter

Two-master, one-slave arbiter for the 32-bit data bus of the pipelined CPU. It shares one memory/peripheral slave between master 0, the CPU load/store port, and master 1, a debug/DMA loader. Requests are handled one at a time. Each granted request is latched, forwarded to the slave and held until the slave signals completion; the response then goes back to the granted master as a one-cycle done pulse.

## Interface
Parameters:
- `FIXED_PRIORITY`, default 0: 0 gives round-robin arbitration; 1 means master 0 always wins a tie.
- `TIMEOUT_CYCLES`, default 255: slave watchdog limit. Used only when `BUS_ARB_TIMEOUT_EN` is defined. Must be ≥ 2.

Ports (reset is asynchronous, active-low; all other behaviour is synchronous to `clk` rising edge):
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous active-low reset
- `m0_addr`, `m1_addr`  in  32  request byte address
- `m0_wdata`, `m1_wdata`  in  32  write data, already lane-aligned
- `m0_wmask`, `m1_wmask`  in  4  byte-lane write mask
- `m0_wen`, `m1_wen`  in  1  write request
- `m0_ren`, `m1_ren`  in  1  read request
- `m0_rdata`, `m1_rdata`  out  32  read response data
- `m0_done`, `m1_done`  out  1  one-cycle completion pulse
- `s_addr`  out  32  slave address
- `s_wdata`  out  32  slave write data
- `s_wmask`  out  4  slave write mask
- `s_wen`, `s_ren`  out  1  slave strobes
- `s_rdata`  in  32  slave read data
- `s_done`  in  1  slave completion
- `grant`  out  2  one-hot active master; 00 when idle
- `timeout_err`  out  1  sticky watchdog flag; tied to 0 when the feature is compiled out

## Operation
- FSM states: `IDLE`, `ISSUE`, `RESP`.
- A master's request is `wen | ren`. If both are set, it is a write and `ren` is ignored.
- **IDLE**
  - If any request is present, pick a winner.
  - Round-robin mode: the master not served last wins a tie.
  - Fixed-priority mode: master 0 wins a tie.
  - Latch the winner's addr, wdata, wmask and op; set `grant`; go to `ISSUE`.
- **ISSUE**
  - Drive `s_*` from the latched registers. Exactly one of `s_wen`/`s_ren` is 1.
  - Master inputs are ignored in this state. Masters must hold them stable anyway.
  - On `s_done`: latch `s_rdata` (writes latch it too, value unused) and go to `RESP`.
- **RESP**
  - Pulse `mX_done` for the granted master for one cycle.
  - `mX_rdata` = latched data. `rdata` holds its value until the next `RESP`. The non-granted master's `done` stays 0.
  - Update the last-served pointer, clear `grant`, go to `IDLE`.
  - Requests are not sampled in `RESP`. A master must drop its strobes in the cycle after `done`, or it will be re-served as a new request.
- **Reset** (`rst` low, any state): go to `IDLE`.
  - All `s_*`, `m*_done`, `grant` and `timeout_err` are 0. `m*_rdata` is 0.
  - Last-served pointer is set to master 1, so master 0 wins the first tie.
  - An in-flight slave access is abandoned. The slave must tolerate strobes dropping.

## Timing
- Request seen in `IDLE` at cycle 0 → `s_ren`/`s_wen` high at cycle 1.
- Slave `s_done` at cycle N ≥ 1 → master `done` at cycle N+1.
- Minimum latency is 2 cycles from request to `done`.
- Throughput is at most one transaction per 3 cycles. `IDLE` always lasts at least one cycle between transactions.
- `s_done` is sampled only in `ISSUE`; a stray `s_done` in other states is ignored.
- `grant` is valid from `ISSUE` through `RESP`.
- Continuous requests from both masters in round-robin mode: grants alternate m0, m1, m0, …

## Configuration
- `BUS_ARB_TIMEOUT_EN` defined:
  - A counter clears on entry to `ISSUE` and increments each cycle in `ISSUE`.
  - At `TIMEOUT_CYCLES` without `s_done`: force `RESP` with rdata = 32'hDEAD_BEEF, set sticky `timeout_err`, drop the slave strobes.
  - `timeout_err` clears only on reset.
- Undefined: no counter is built; `ISSUE` waits indefinitely; `timeout_err` = 0.

## Structure
- Package `bus_arb_pkg` holds:
  - state enum `bus_arb_state_t` (`IDLE`, `ISSUE`, `RESP`)
  - typedef `bus_arb_req_t` struct: addr, wdata, wmask, is_write
  - constant `BUS_ARB_TIMEOUT_DATA` = 32'hDEAD_BEEF
- Sub-module `bus_arb_rr_pick`: combinational two-input picker. Inputs are the request vector, last-served pointer and `FIXED_PRIORITY`; output is a one-hot winner.

## Test plan
- m0 read 0x0000_1004, slave returns 0xCAFE_F00D with `s_done` in the same cycle it sees `s_ren` → `m0_done` 2 cycles after request; `m0_rdata` = 0xCAFE_F00D; `m1_done` = 0.
- m1 write 0x2000_0000, wdata 0x0000_00AB, wmask 0001; slave delays `s_done` by 5 cycles → `s_wmask` = 0001 held for 5 cycles; `m1_done` pulses one cycle after `s_done`.
- Both masters request continuously, round-robin → grant sequence m0, m1, m0, m1. With `FIXED_PRIORITY` = 1 → m0 every time.
- m0 sets both `wen` and `ren` → slave sees a write only; `s_ren` = 0.
- Assert `rst` low in `ISSUE` mid-access → all outputs 0 immediately. After release, master 0 wins the first tie.
- With `BUS_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES` = 8, slave never answers → `m0_done` with 0xDEAD_BEEF, `timeout_err` = 1 and stays set.
